his_lut_ctrl: RTL and testbench
===============================

HIS_LUT_CTRL -- requirements
Module: his_lut_ctrl

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, meaning the width of the histogram count word.
REQ-002 SHALL have parameter C_VDATA_WIDTH, default 8, meaning pixel width; the LUT depth is 2^C_VDATA_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 SHALL have port vs_in  input  1  vertical sync, active high; a rising edge marks frame start.
REQ-006 SHALL have port his_valid  input  1  valid for the histogram output stream.
REQ-007 SHALL have port his_ready  output  1  ready for the histogram output stream.
REQ-008 SHALL have port his_data  input  C_DATA_WIDTH  the stream: first word is total count N, then 2^V cumulative counts for bin 0 up to bin 2^V-1.
REQ-009 SHALL have port lut_we  output  1  LUT write strobe.
REQ-010 SHALL have port lut_waddr  output  C_VDATA_WIDTH  LUT write address (bin index).
REQ-011 SHALL have port lut_wdata  output  C_VDATA_WIDTH  mapped pixel value.
REQ-012 SHALL have port lut_bank  output  1  bank being written; always equals ~disp_bank.
REQ-013 SHALL have port disp_bank  output  1  bank used by the pixel mapper.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port lut_done  output  1  one-cycle pulse when the last bin has been written.
REQ-016 SHALL have port err_overrun  output  1  sticky flag: a vs_in rising edge occurred while busy.

Function
REQ-017 SHALL implement the states IDLE, GET_BIN, DIV, WRITE and DONE.
REQ-018 SHALL drive his_ready=1 only in IDLE and GET_BIN.
REQ-019 SHALL treat a handshake (his_valid & his_ready) in IDLE as loading N into a register, then go to GET_BIN with the bin counter cleared to 0.
REQ-020 SHALL, on a GET_BIN handshake, capture cdf=his_data and go to DIV.
REQ-021 SHALL compute lut_wdata in DIV by these rules, evaluated in order:
- N==0: lut_wdata = bin index.
- cdf>=N: lut_wdata = 2^V-1.
- otherwise: lut_wdata = floor(cdf*(2^V-1)/N), using a (C_DATA_WIDTH+C_VDATA_WIDTH)-bit product and a restoring divider that produces one quotient bit per clock, MSB first.
REQ-022 SHALL spend exactly C_VDATA_WIDTH cycles in DIV for every case, including the special cases.
REQ-023 SHALL assert lut_we for exactly one cycle in WRITE, with lut_waddr set to the bin counter.
REQ-024 SHALL leave WRITE on the following rule:
- bin counter < 2^V-1: increment the bin counter and return to GET_BIN.
- bin counter = 2^V-1: go to DONE; no wrap-around to a new bin.
- Latency from bin handshake to lut_we is C_VDATA_WIDTH+1 cycles.
REQ-025 SHALL pulse lut_done in DONE, set a swap_pending flag, and return to IDLE on the next cycle.
REQ-026 SHALL detect a vs_in rising edge using a registered copy of vs_in.
REQ-027 SHALL, when a vs_in rising edge occurs with swap_pending=1 and not busy, toggle disp_bank and clear swap_pending.
REQ-028 SHALL, when a vs_in rising edge occurs while busy, set err_overrun, continue the sequence, and defer the swap to the first vs_in rising edge after DONE.
REQ-029 SHALL hold disp_bank when a vs_in rising edge coincides with the lut_done cycle; the swap occurs on a later edge.
REQ-030 SHALL clear err_overrun only by reset.
REQ-031 SHALL ignore his_data outside handshakes.

Reset
REQ-032 SHALL, when reset=1 at a clk edge, force the following, overriding all other events:
- state to IDLE; bin counter, N, cdf and swap_pending to 0.
- his_ready=1.
- lut_we, lut_waddr, lut_wdata, busy, lut_done and err_overrun to 0.
- disp_bank=0 and lut_bank=1.
REQ-033 SHALL, when reset is applied mid-sequence, discard the partial LUT and perform no bank swap.

Configuration
REQ-034 SHALL provide the macro HIS_LUT_BYPASS_EN as the only compile-time option.
REQ-035 SHALL, when HIS_LUT_BYPASS_EN is defined:
- add port bypass_in  input  1.
- if bypass_in=1 at a GET_BIN handshake, skip DIV, go directly to WRITE on the next cycle, and write lut_wdata = bin index.
REQ-036 SHALL, when HIS_LUT_BYPASS_EN is undefined, omit bypass_in and always compute via DIV.

Verification
REQ-037 SHALL cover: N=1000, cdf values all 500 -> every lut_wdata=127, 256 lut_we pulses, each C_VDATA_WIDTH+1 cycles after its handshake.
REQ-038 SHALL cover: N=1000, bin 255 cdf=1000 and bin 254 cdf=1200 -> lut_wdata=255 for both, then one lut_done pulse.
REQ-039 SHALL cover: N=0 -> lut_wdata equals lut_waddr for all bins.
REQ-040 SHALL cover: sequence completes, then a vs_in rising edge -> disp_bank goes 0->1 and lut_bank goes 1->0; a second edge with no new sequence -> no toggle.
REQ-041 SHALL cover: vs_in rising edge at bin 100 -> err_overrun=1, sequence finishes, swap occurs on the next edge only.
REQ-042 SHALL cover: reset asserted in DIV at bin 50 -> next cycle state IDLE, his_ready=1, busy=0, and no swap on the following vs_in edge.

Source files
------------

// File: rtl/his_lut_ctrl.sv
// Histogram-equalisation LUT builder: turns a {N, cdf[0..2^V-1]} stream into LUT writes
// and ping-pongs the LUT bank on vs_in. Optional bypass_in port: define HIS_LUT_BYPASS_EN.
module his_lut_ctrl #(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_VDATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vs_in,
    input  logic                     his_valid,
    output logic                     his_ready,
    input  logic [C_DATA_WIDTH-1:0]  his_data,
`ifdef HIS_LUT_BYPASS_EN
    input  logic                     bypass_in,
`endif
    output logic                     lut_we,
    output logic [C_VDATA_WIDTH-1:0] lut_waddr,
    output logic [C_VDATA_WIDTH-1:0] lut_wdata,
    output logic                     lut_bank,
    output logic                     disp_bank,
    output logic                     busy,
    output logic                     lut_done,
    output logic                     err_overrun
);

    localparam int DW = C_DATA_WIDTH;
    localparam int VW = C_VDATA_WIDTH;
    localparam int PW = DW + VW;
    localparam int CW = $clog2(VW) + 1;
    localparam logic [VW-1:0] BIN_LAST = {VW{1'b1}};
    localparam logic [CW-1:0] DIV_LAST = CW'(VW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_BIN,
        ST_DIV,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] bin_q, bin_d;
    logic [DW-1:0] n_q, n_d;
    logic [DW-1:0] cdf_q, cdf_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [VW-1:0] sh_q, sh_d;
    logic [VW-1:0] quot_q, quot_d;
    logic [VW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vs_q, vs_d;
    logic          disp_q, disp_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d;

    logic          bypass_req;
`ifdef HIS_LUT_BYPASS_EN
    assign bypass_req = bypass_in;
`else
    assign bypass_req = 1'b0;
`endif

    logic [PW-1:0] data_ext;
    logic [PW-1:0] prod;
    logic [DW:0]   trial;
    logic          q_bit;
    logic [DW-1:0] rem_next;
    logic [VW-1:0] quot_next;
    logic          vs_rise;
    logic          busy_w;

    // cdf*(2^V-1) as a shift and subtract; the top DW bits start the division
    // because cdf<N guarantees they are already below N.
    always_comb begin
        data_ext  = PW'(his_data);
        prod      = (data_ext << VW) - data_ext;
        trial     = {rem_q, sh_q[VW-1]};
        q_bit     = (trial >= {1'b0, n_q});
        rem_next  = q_bit ? (trial[DW-1:0] - n_q) : trial[DW-1:0];
        quot_next = {quot_q[VW-2:0], q_bit};
        vs_rise   = vs_in & ~vs_q;
        busy_w    = (state_q != ST_IDLE);
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        n_d     = n_q;
        cdf_d   = cdf_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        quot_d  = quot_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        vs_d    = vs_in;
        disp_d  = disp_q;
        pend_d  = pend_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (his_valid) begin
                    n_d     = his_data;
                    bin_d   = '0;
                    state_d = ST_GET_BIN;
                end
            end
            ST_GET_BIN: begin
                if (his_valid) begin
                    cdf_d = his_data;
                    if (bypass_req) begin
                        wdata_d = bin_q;
                        state_d = ST_WRITE;
                    end else begin
                        rem_d   = prod[PW-1:VW];
                        sh_d    = prod[VW-1:0];
                        quot_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                rem_d  = rem_next;
                sh_d   = sh_q << 1;
                quot_d = quot_next;
                cnt_d  = cnt_q + CW'(1);
                // Special cases still run the full divider length so timing is fixed.
                if (cnt_q == DIV_LAST) begin
                    if (n_q == '0) begin
                        wdata_d = bin_q;
                    end else if (cdf_q >= n_q) begin
                        wdata_d = '1;
                    end else begin
                        wdata_d = quot_next;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bin_q == BIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    bin_d   = bin_q + VW'(1);
                    state_d = ST_GET_BIN;
                end
            end
            ST_DONE: begin
                pend_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An edge during DONE counts as busy, so the fresh LUT waits for a later edge.
        if (vs_rise) begin
            if (busy_w) begin
                err_d = 1'b1;
            end else if (pend_q) begin
                disp_d = ~disp_q;
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            n_q     <= '0;
            cdf_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            quot_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            vs_q    <= 1'b0;
            disp_q  <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            n_q     <= n_d;
            cdf_q   <= cdf_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            quot_q  <= quot_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            vs_q    <= vs_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        his_ready   = (state_q == ST_IDLE) || (state_q == ST_GET_BIN);
        busy        = busy_w;
        lut_we      = (state_q == ST_WRITE);
        lut_waddr   = bin_q;
        lut_wdata   = wdata_q;
        lut_done    = (state_q == ST_DONE);
        disp_bank   = disp_q;
        lut_bank    = ~disp_q;
        err_overrun = err_q;
    end

endmodule

// File: tb/tb_his_lut_ctrl.sv
// Bench for his_lut_ctrl: table-driven full sequences, randomized sequences against a
// plain-arithmetic model, and hand-written bank-swap / overrun / reset corner cases.
module tb_his_lut_ctrl;
    localparam int DW = 32;
    localparam int VW = 8;
    localparam int NB = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          vs_in;
    logic          his_valid;
    logic          his_ready;
    logic [DW-1:0] his_data;
    logic          lut_we;
    logic [VW-1:0] lut_waddr;
    logic [VW-1:0] lut_wdata;
    logic          lut_bank;
    logic          disp_bank;
    logic          busy;
    logic          lut_done;
    logic          err_overrun;
`ifdef HIS_LUT_BYPASS_EN
    logic          bypass_in = 1'b0;
`endif

    his_lut_ctrl #(.C_DATA_WIDTH(DW), .C_VDATA_WIDTH(VW)) dut (
        .clk(clk), .reset(reset), .vs_in(vs_in),
        .his_valid(his_valid), .his_ready(his_ready), .his_data(his_data),
`ifdef HIS_LUT_BYPASS_EN
        .bypass_in(bypass_in),
`endif
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .lut_bank(lut_bank), .disp_bank(disp_bank), .busy(busy),
        .lut_done(lut_done), .err_overrun(err_overrun)
    );

    // clock/reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [15:0]   exp_q[$];
    int            hs_q[$];
    int            done_cnt = 0;
    logic [DW-1:0] cdf_arr[NB];
    logic [VW-1:0] exp_arr[NB];

    typedef struct {
        logic [DW-1:0] n;
        logic [DW-1:0] cdf;
        bit            exp_is_bin;
        logic [VW-1:0] exp_wd;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [VW-1:0] ref_map(input longint unsigned n, input longint unsigned cdf,
                                               input int bin);
        longint unsigned q;
        if (n == 0) return VW'(bin);
        if (cdf >= n) return {VW{1'b1}};
        q = (cdf * 255) / n;
        return VW'(q);
    endfunction

    // scoreboard: every LUT write is matched against the expected queue
    always @(negedge clk) begin
        logic [15:0] e;
        int h;
        logic nb;
        if (lut_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we actual addr=%0h data=%0h required none", lut_waddr, lut_wdata);
            end else begin
                e  = exp_q.pop_front();
                h  = hs_q.pop_front();
                nb = ~disp_bank;
                check("lut_waddr", lut_waddr, e[15:8]);
                check("lut_wdata", lut_wdata, e[7:0]);
                check("we_latency", cyc - h, VW + 1);
                check("lut_bank_inv", lut_bank, nb);
            end
        end
        if (lut_done === 1'b1) done_cnt++;
    end

    // driver tasks
    task automatic send_word(input logic [DW-1:0] d, output bit ok, output int hcyc);
        his_valid = 1'b1;
        his_data  = d;
        ok        = 1'b0;
        hcyc      = 0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (his_ready === 1'b1) begin
                ok   = 1'b1;
                hcyc = cyc;
            end
            @(negedge clk);
        end
        his_valid = 1'b0;
        his_data  = $urandom();
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout actual=no_ready required=ready within 64 cycles");
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic run_seq(input logic [DW-1:0] n, input bit gaps, input int vs_bin,
                           input bit vs_at_done, input int reset_bin, output bit aborted);
        bit ok;
        int h;
        int d0;
        logic [VW-1:0] b8;
        aborted = 1'b0;
        d0 = done_cnt;
        send_word(n, ok, h);
        if (!ok) return;
        for (int b = 0; b < NB; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            send_word(cdf_arr[b], ok, h);
            if (!ok) return;
            b8 = VW'(b);
            exp_q.push_back({b8, exp_arr[b]});
            hs_q.push_back(h);
            if (b == vs_bin) vs_in = 1'b1;
            if (b == vs_bin + 1) vs_in = 1'b0;
            if (b == reset_bin) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                exp_q.delete();
                hs_q.delete();
                aborted = 1'b1;
                return;
            end
        end
        if (vs_at_done) begin
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (lut_done === 1'b1) break;
            end
            vs_in = 1'b1;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_cnt != d0) break;
        end
        idle_cycles(2);
        check("lut_done_count", done_cnt - d0, 1);
        check("writes_outstanding", exp_q.size(), 0);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic vs_edge_check(input string name, input logic exp_disp);
        logic nb;
        vs_in = 1'b1;
        idle_cycles(2);
        vs_in = 1'b0;
        idle_cycles(1);
        nb = ~exp_disp;
        check(name, disp_bank, exp_disp);
        check({name, "_lut_bank"}, lut_bank, nb);
    endtask

    task automatic fill_random(input longint unsigned n, input longint unsigned hi);
        for (int b = 0; b < NB; b++) begin
            cdf_arr[b] = DW'($urandom_range(0, 32'(hi)));
            exp_arr[b] = ref_map(n, cdf_arr[b], b);
        end
    endtask

    initial begin
        bit ab;
        logic [DW-1:0] n;

        tbl[0] = '{32'd1000, 32'd500, 1'b0, 8'd127};
        tbl[1] = '{32'd1000, 32'd1000, 1'b0, 8'd255};
        tbl[2] = '{32'd1000, 32'd1200, 1'b0, 8'd255};
        tbl[3] = '{32'd0, 32'd77, 1'b1, 8'd0};
        tbl[4] = '{32'd1000, 32'd0, 1'b0, 8'd0};
        tbl[5] = '{32'd3, 32'd1, 1'b0, 8'd85};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 8'd254};
        tbl[7] = '{32'd7, 32'd6, 1'b0, 8'd218};

        reset = 1'b1;
        vs_in = 1'b0;
        his_valid = 1'b0;
        his_data = '0;
        idle_cycles(3);
        check("rst_his_ready", his_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_lut_we", lut_we, 1'b0);
        check("rst_lut_waddr", lut_waddr, 0);
        check("rst_lut_wdata", lut_wdata, 0);
        check("rst_lut_done", lut_done, 1'b0);
        check("rst_err_overrun", err_overrun, 1'b0);
        check("rst_disp_bank", disp_bank, 1'b0);
        check("rst_lut_bank", lut_bank, 1'b1);
        reset = 1'b0;
        idle_cycles(1);

        for (int v = 0; v < 8; v++) begin
            for (int b = 0; b < NB; b++) begin
                cdf_arr[b] = tbl[v].cdf;
                exp_arr[b] = tbl[v].exp_is_bin ? VW'(b) : tbl[v].exp_wd;
            end
            run_seq(tbl[v].n, 1'b0, -1, 1'b0, -1, ab);
        end
        check("no_swap_without_vs", disp_bank, 1'b0);

        vs_edge_check("swap_after_done", 1'b1);
        vs_edge_check("no_swap_second_edge", 1'b1);

        // saturation at the top bins, random lower bins, valid gaps
        fill_random(1000, 1100);
        cdf_arr[254] = 32'd1200;
        exp_arr[254] = 8'd255;
        cdf_arr[255] = 32'd1000;
        exp_arr[255] = 8'd255;
        run_seq(32'd1000, 1'b1, -1, 1'b0, -1, ab);
        vs_edge_check("swap_seq_sat", 1'b0);

        n = DW'($urandom_range(1, 1 << 20));
        fill_random(n, longint'(n) + 100);
        run_seq(n, 1'b1, -1, 1'b0, -1, ab);
        vs_edge_check("swap_seq_rand", 1'b1);

        n = $urandom() | 32'h8000_0000;
        for (int b = 0; b < NB; b++) begin
            cdf_arr[b] = $urandom();
            exp_arr[b] = ref_map(n, cdf_arr[b], b);
        end
        run_seq(n, 1'b1, -1, 1'b0, -1, ab);
        vs_edge_check("swap_seq_big", 1'b0);

        // vs edge while busy at bin 100
        fill_random(1000, 1000);
        run_seq(32'd1000, 1'b0, 100, 1'b0, -1, ab);
        check("overrun_flag", err_overrun, 1'b1);
        check("overrun_no_swap", disp_bank, 1'b0);
        vs_edge_check("overrun_deferred_swap", 1'b1);
        vs_edge_check("overrun_single_swap", 1'b1);
        check("overrun_sticky", err_overrun, 1'b1);

        // vs edge in the lut_done cycle
        fill_random(500, 600);
        run_seq(32'd500, 1'b0, -1, 1'b1, -1, ab);
        check("done_edge_hold", disp_bank, 1'b1);
        vs_in = 1'b0;
        idle_cycles(1);
        vs_edge_check("done_edge_later_swap", 1'b0);

        // reset in DIV at bin 50
        fill_random(1000, 1000);
        run_seq(32'd1000, 1'b0, -1, 1'b0, 50, ab);
        check("reset_aborted", ab, 1'b1);
        check("reset_his_ready", his_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_lut_we", lut_we, 1'b0);
        check("reset_err_cleared", err_overrun, 1'b0);
        check("reset_lut_bank", lut_bank, 1'b1);
        vs_edge_check("reset_no_swap", 1'b0);
        idle_cycles(20);
        check("reset_no_done", lut_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
